dcache_ctrl: RTL and testbench

Data-cache controller for the MEM stage: sequences a direct-mapped, write-back, write-allocate data cache between the pipeline and a single-ported backing-memory bus. It owns the tag/valid/dirty state, drives the external data-array SRAM (whose read word feeds the write-back stage's `cache_data_out` byte lanes), performs dirty-line eviction and 4-word line refill, and stalls the pipeline until the access hits.

---
 rtl/mips_cache_pkg.sv | 33 +++
 rtl/dcache_tag_store.sv | 55 +++++
 rtl/dcache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cache_pkg.sv
// Shared definitions for the MEM-stage data cache.
// Contents:
//   cache_state_t - controller FSM states (IDLE, EVICT, FILL)
//   address field offsets/widths within a 32-bit byte address
//   byte_en()     - big-endian byte-lane write-enable decode
package mips_cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVICT = 2'd1,
      ST_FILL  = 2'd2
   } cache_state_t;

   localparam int BYTE_LSB  = 0;
   localparam int WORD_LSB  = 2;
   localparam int WORD_W    = 2;
   localparam int INDEX_LSB = 4;

   localparam logic [WORD_W-1:0] LAST_WORD = 2'd3;

   // Byte offset 0 is the most significant lane (big-endian).
   function automatic logic [3:0] byte_en(input logic [1:0] off);
      logic [3:0] be;
      case (off)
         2'd0:    be = 4'b1000;
         2'd1:    be = 4'b0100;
         2'd2:    be = 4'b0010;
         default: be = 4'b0001;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Tag/valid/dirty state for a direct-mapped cache.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (clears valid/dirty)
//   index        - line selected for lookup and update
//   rd_tag       - stored tag of the selected line (combinational)
//   rd_valid     - valid bit of the selected line (combinational)
//   rd_dirty     - dirty bit of the selected line (combinational)
//   set_dirty    - mark the selected line dirty at the clock edge
//   fill         - install fill_tag, valid=1, dirty=0 at the clock edge
//   fill_tag     - tag written on fill
module dcache_tag_store #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 22
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] index,
   output logic [TAG_W-1:0]   rd_tag,
   output logic               rd_valid,
   output logic               rd_dirty,
   input  logic               set_dirty,
   input  logic               fill,
   input  logic [TAG_W-1:0]   fill_tag
);

   localparam int LINES = 1 << INDEX_W;

   logic [TAG_W-1:0] tags [LINES];
   logic [LINES-1:0] valid;
   logic [LINES-1:0] dirty;

   // Tags need no reset: they are qualified by valid.
   always_ff @(posedge clk) begin
      if (fill) begin
         tags[index] <= fill_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill) begin
         valid[index] <= 1'b1;
         dirty[index] <= 1'b0;
      end else if (set_dirty) begin
         dirty[index] <= 1'b1;
      end
   end

   assign rd_tag   = tags[index];
   assign rd_valid = valid[index];
   assign rd_dirty = dirty[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_valid/write/is_word/addr/wdata - MEM-stage access
//   stall                         - hold the pipeline until the access hits
//   arr_index/word/we/wdata/rdata - external data-array SRAM interface
//   mem_req/we/addr/wdata/ack/rdata - single-ported backing-memory bus
//   miss_count                    - saturating miss counter
module dcache_ctrl
   import mips_cache_pkg::*;
#(
   parameter int INDEX_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic               req_write,
   input  logic               req_is_word,
   input  logic [31:0]        req_addr,
   input  logic [31:0]        req_wdata,
   output logic               stall,
   output logic [INDEX_W-1:0] arr_index,
   output logic [1:0]         arr_word,
   output logic [3:0]         arr_we,
   output logic [31:0]        arr_wdata,
   input  logic [31:0]        arr_rdata,
   output logic               mem_req,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata,
   output logic [31:0]        miss_count
);

   localparam int TAG_W = 32 - INDEX_LSB - INDEX_W;

   cache_state_t state, state_nxt;
   logic [WORD_W-1:0] cnt, cnt_nxt;
   logic [31:0]       miss_cnt;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic [WORD_W-1:0]  word;
   logic [1:0]         off;

   logic [TAG_W-1:0] line_tag;
   logic             line_valid;
   logic             line_dirty;
   logic             hit;
   logic             set_dirty;
   logic             fill_done;
   logic             miss;

   assign idx  = req_addr[INDEX_LSB +: INDEX_W];
   assign tag  = req_addr[31 -: TAG_W];
   assign word = req_addr[WORD_LSB +: WORD_W];
   assign off  = req_addr[BYTE_LSB +: 2];

   dcache_tag_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_tags (
      .clk       (clk),
      .rst       (rst),
      .index     (idx),
      .rd_tag    (line_tag),
      .rd_valid  (line_valid),
      .rd_dirty  (line_dirty),
      .set_dirty (set_dirty),
      .fill      (fill_done),
      .fill_tag  (tag)
   );

   assign hit = req_valid && line_valid && (line_tag == tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         miss_cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (miss && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end

   assign miss_count = miss_cnt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      arr_index = idx;
      arr_word  = word;
      arr_we    = '0;
      arr_wdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      set_dirty = 1'b0;
      fill_done = 1'b0;
      miss      = 1'b0;

      case (state)
         ST_IDLE: begin
            // rst gates the request so stall stays low throughout reset.
            if (req_valid && !rst) begin
               if (hit) begin
                  if (req_write) begin
                     set_dirty = 1'b1;
                     if (req_is_word) begin
                        arr_we    = '1;
                        arr_wdata = req_wdata;
                     end else begin
                        arr_we    = byte_en(off);
                        arr_wdata = {4{req_wdata[7:0]}};
                     end
                  end
               end else begin
                  stall     = 1'b1;
                  miss      = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = (line_valid && line_dirty) ? ST_EVICT : ST_FILL;
               end
            end
         end

         ST_EVICT: begin
            stall     = 1'b1;
            arr_word  = cnt;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {line_tag, idx, cnt, 2'b00};
            mem_wdata = arr_rdata;
            if (mem_ack) begin
               // Wraps to 0 after the last word, ready for the fill.
               cnt_nxt = cnt + 2'd1;
               if (cnt == LAST_WORD) begin
                  state_nxt = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            stall    = 1'b1;
            arr_word = cnt;
            mem_req  = 1'b1;
            mem_addr = {tag, idx, cnt, 2'b00};
            if (mem_ack) begin
               arr_we    = '1;
               arr_wdata = mem_rdata;
               cnt_nxt   = cnt + 2'd1;
               if (cnt == LAST_WORD) begin
                  fill_done = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a data-array model
// and a backing-memory responder with programmable ack latency.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic        req_is_word;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [5:0]  arr_index;
   logic [1:0]  arr_word;
   logic [3:0]  arr_we;
   logic [31:0] arr_wdata;
   logic [31:0] arr_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] miss_count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] darr [256];
   logic [31:0] bmem [1024];
   int          ack_delay = 0;
   int          wcnt = 0;

   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic        log_we   [$];

   dcache_ctrl #(.INDEX_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_is_word (req_is_word),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .stall       (stall),
      .arr_index   (arr_index),
      .arr_word    (arr_word),
      .arr_we      (arr_we),
      .arr_wdata   (arr_wdata),
      .arr_rdata   (arr_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .miss_count  (miss_count)
   );

   always #5 clk = ~clk;

   assign arr_rdata = darr[{arr_index, arr_word}];

   always @(posedge clk) begin
      if (arr_we[3]) darr[{arr_index, arr_word}][31:24] = arr_wdata[31:24];
      if (arr_we[2]) darr[{arr_index, arr_word}][23:16] = arr_wdata[23:16];
      if (arr_we[1]) darr[{arr_index, arr_word}][15:8]  = arr_wdata[15:8];
      if (arr_we[0]) darr[{arr_index, arr_word}][7:0]   = arr_wdata[7:0];
   end

   always @(posedge clk) begin
      if (!rst && mem_req && mem_ack) begin
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_data.push_back(mem_we ? mem_wdata : mem_rdata);
         if (mem_we) bmem[mem_addr[11:2]] = mem_wdata;
      end
   end

   // Ack after ack_delay wait cycles per word.
   always @(negedge clk) begin
      if (mem_req) begin
         if (wcnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = bmem[mem_addr[11:2]];
            wcnt      = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end
   end

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_we.delete();
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Applies a request and counts stall cycles until it completes.
   task automatic access(input logic w, input logic is_word, input logic [31:0] a,
                         input logic [31:0] d, output int stalls, output logic [31:0] rd,
                         output logic [3:0] we, output logic [31:0] wd, output logic addr_ok);
      logic        held;
      logic [31:0] prev;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = w; req_is_word = is_word;
      req_addr = a; req_wdata = d;
      stalls = 0; addr_ok = 1'b1; held = 1'b0; prev = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (!stall) break;
         stalls++;
         if (mem_req && held && (mem_addr !== prev)) addr_ok = 1'b0;
         held = mem_req && !mem_ack;
         prev = mem_addr;
      end
      if (stall) stalls = -1;
      rd = arr_rdata; we = arr_we; wd = arr_wdata;
   endtask

   int          st;
   logic [31:0] rd;
   logic [3:0]  we;
   logic [31:0] wd;
   logic        aok;

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_is_word = 1'b1;
      req_addr = 32'h100; req_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      checks++; if (arr_we !== 4'b0) begin failures++; $display("FAIL reset_arr_we got=%b exp=0000", arr_we); end
      checks++; if (miss_count !== 32'd0) begin failures++; $display("FAIL reset_miss_count got=%h exp=0", miss_count); end
      req_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_idle_no_req();
      req_valid = 1'b0; req_addr = 32'h240;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", stall); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_mem_req got=%b exp=0", mem_req); end
      checks++; if (miss_count !== 32'd0) begin failures++; $display("FAIL idle_miss_count got=%h exp=0", miss_count); end
   endtask

   task automatic test_clean_fill();
      clear_log();
      access(1'b0, 1'b1, 32'h100, 32'h0, st, rd, we, wd, aok);
      checks++; if (st !== 5) begin failures++; $display("FAIL clean_stalls got=%0d exp=5", st); end
      checks++; if (log_addr.size() !== 4) begin failures++; $display("FAIL clean_xfers got=%0d exp=4", log_addr.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[i] !== (32'h100 + 32'(i * 4)) || log_we[i] !== 1'b0) begin
               failures++; $display("FAIL clean_fill_addr%0d got=%h we=%b exp=%h we=0", i, log_addr[i], log_we[i], 32'h100 + 32'(i * 4));
            end
         end
      end
      checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL clean_rdata got=%h exp=deadbeef", rd); end
      checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL clean_miss_count got=%h exp=1", miss_count); end
   endtask

   task automatic test_byte_store();
      clear_log();
      access(1'b1, 1'b0, 32'h101, 32'h000000AB, st, rd, we, wd, aok);
      checks++; if (st !== 0) begin failures++; $display("FAIL bstore_stalls got=%0d exp=0", st); end
      checks++; if (we !== 4'b0100) begin failures++; $display("FAIL bstore_we got=%b exp=0100", we); end
      checks++; if (wd !== 32'hABABABAB) begin failures++; $display("FAIL bstore_wdata got=%h exp=abababab", wd); end
      access(1'b0, 1'b1, 32'h100, 32'h0, st, rd, we, wd, aok);
      checks++; if (st !== 0) begin failures++; $display("FAIL bload_stalls got=%0d exp=0", st); end
      checks++; if (rd !== 32'hDEABBEEF) begin failures++; $display("FAIL bload_rdata got=%h exp=deabbeef", rd); end
      checks++; if (we !== 4'b0000) begin failures++; $display("FAIL bload_we got=%b exp=0000", we); end
      checks++; if (log_addr.size() !== 0) begin failures++; $display("FAIL hit_bus_traffic got=%0d exp=0", log_addr.size()); end
      checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL bstore_miss_count got=%h exp=1", miss_count); end
   endtask

   task automatic test_dirty_evict();
      clear_log();
      access(1'b0, 1'b1, 32'h500, 32'h0, st, rd, we, wd, aok);
      checks++; if (st !== 9) begin failures++; $display("FAIL evict_stalls got=%0d exp=9", st); end
      checks++; if (log_addr.size() !== 8) begin failures++; $display("FAIL evict_xfers got=%0d exp=8", log_addr.size()); end
      else begin
         checks++;
         if (log_addr[0] !== 32'h100 || log_we[0] !== 1'b1 || log_data[0] !== 32'hDEABBEEF) begin
            failures++; $display("FAIL evict_word0 got=%h/%b/%h exp=100/1/deabbeef", log_addr[0], log_we[0], log_data[0]);
         end
         checks++;
         if (log_addr[3] !== 32'h10C || log_we[3] !== 1'b1 || log_data[3] !== 32'h1000010C) begin
            failures++; $display("FAIL evict_word3 got=%h/%b/%h exp=10c/1/1000010c", log_addr[3], log_we[3], log_data[3]);
         end
         checks++;
         if (log_addr[4] !== 32'h500 || log_we[4] !== 1'b0) begin
            failures++; $display("FAIL evict_fill0 got=%h/%b exp=500/0", log_addr[4], log_we[4]);
         end
         checks++;
         if (log_addr[7] !== 32'h50C || log_we[7] !== 1'b0) begin
            failures++; $display("FAIL evict_fill3 got=%h/%b exp=50c/0", log_addr[7], log_we[7]);
         end
      end
      checks++; if (rd !== 32'h10000500) begin failures++; $display("FAIL evict_rdata got=%h exp=10000500", rd); end
      checks++; if (miss_count !== 32'd2) begin failures++; $display("FAIL evict_miss_count got=%h exp=2", miss_count); end
   endtask

   task automatic test_delayed_ack();
      ack_delay = 3;
      access(1'b0, 1'b1, 32'h200, 32'h0, st, rd, we, wd, aok);
      ack_delay = 0;
      checks++; if (st !== 17) begin failures++; $display("FAIL delay_stalls got=%0d exp=17", st); end
      checks++; if (aok !== 1'b1) begin failures++; $display("FAIL delay_addr_stable got=%b exp=1", aok); end
      checks++; if (rd !== 32'h10000200) begin failures++; $display("FAIL delay_rdata got=%h exp=10000200", rd); end
      checks++; if (miss_count !== 32'd3) begin failures++; $display("FAIL delay_miss_count got=%h exp=3", miss_count); end
   endtask

   task automatic test_reset_mid_fill();
      logic found;
      found = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_is_word = 1'b1; req_addr = 32'h300;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (mem_req && !mem_we && mem_addr === 32'h308) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (found !== 1'b1) begin failures++; $display("FAIL rstfill_reach got=%b exp=1", found); end
      rst = 1'b1; req_valid = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstfill_mem_req got=%b exp=0", mem_req); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstfill_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (miss_count !== 32'd0) begin failures++; $display("FAIL rstfill_miss_count got=%h exp=0", miss_count); end
      access(1'b0, 1'b1, 32'h300, 32'h0, st, rd, we, wd, aok);
      checks++; if (st !== 5) begin failures++; $display("FAIL rstfill_remiss_stalls got=%0d exp=5", st); end
      checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL rstfill_remiss_count got=%h exp=1", miss_count); end
      checks++; if (rd !== 32'h10000300) begin failures++; $display("FAIL rstfill_rdata got=%h exp=10000300", rd); end
   endtask

   task automatic test_miss_saturate();
      @(negedge clk);
      force dut.miss_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.miss_cnt;
      #1;
      checks++; if (miss_count !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sat_preload got=%h exp=fffffffe", miss_count); end
      access(1'b0, 1'b1, 32'h400, 32'h0, st, rd, we, wd, aok);
      checks++; if (st !== 5) begin failures++; $display("FAIL sat_stalls1 got=%0d exp=5", st); end
      checks++; if (miss_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_count1 got=%h exp=ffffffff", miss_count); end
      access(1'b0, 1'b1, 32'h800, 32'h0, st, rd, we, wd, aok);
      checks++; if (st !== 5) begin failures++; $display("FAIL sat_stalls2 got=%0d exp=5", st); end
      checks++; if (miss_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_count2 got=%h exp=ffffffff", miss_count); end
      checks++; if (rd !== 32'h10000800) begin failures++; $display("FAIL sat_rdata got=%h exp=10000800", rd); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) bmem[i] = 32'h1000_0000 | 32'(i * 4);
      bmem[32'h40] = 32'hDEADBEEF;
      for (int i = 0; i < 256; i++) darr[i] = '0;
      test_reset();
      test_idle_no_req();
      test_clean_fill();
      test_byte_store();
      test_dirty_evict();
      test_delayed_ack();
      go_idle();
      test_reset_mid_fill();
      go_idle();
      test_miss_saturate();
      go_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
